// File: rtl/multicycle_core_if.sv
// Memory-side bus of multicycle_core: instruction fetch port and data load/store port,
// each with a req/ack handshake so wait-state memories can stall the core.
interface multicycle_core_if #(
    parameter int DATA_W = 16
);
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_ack;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-instruction processor: FETCH/DECODE/EXEC/MEM/WB sequencing over
// handshaked instruction and data memories, with r0-hardwired register file and flags.
module multicycle_core #(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 8,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 2
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_core_if.master   bus,
    output logic                halted,
    output logic                retire,
    output logic                flag_zero,
    output logic                flag_neg,
    output logic                flag_carry
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    logic [2:0]        state_reg;
    logic [DATA_W-1:0] pc_reg;
    logic [15:0]       ir_reg;
    logic [DATA_W-1:0] a_reg, b_reg, imm_reg, res_reg;
    logic              zero_reg, neg_reg, carry_reg;
    logic [DATA_W-1:0] regs [NREGS];

    logic [2:0] op, rs, rt, rd;
    logic [3:0] funct;
    assign op    = ir_reg[2:0];
    assign rs    = ir_reg[5:3];
    assign rt    = ir_reg[8:6];
    assign rd    = ir_reg[11:9];
    assign funct = ir_reg[15:12];

    logic is_r, r_valid, is_addi, is_lw, is_sw, is_beq, is_halt, is_nop;
    assign is_r    = (op == 3'b000);
    assign r_valid = is_r && (funct <= 4'd4);
    assign is_addi = (op == 3'b001);
    assign is_lw   = (op == 3'b010);
    assign is_sw   = (op == 3'b011);
    assign is_beq  = (op == 3'b100);
    assign is_halt = (op == 3'b111);
    assign is_nop  = (is_r && !r_valid) || (op == 3'b101) || (op == 3'b110);

    logic [DATA_W-1:0] rs_val, rt_val, imm_sext;
    assign rs_val   = (rs == 3'd0) ? '0 : regs[rs];
    assign rt_val   = (rt == 3'd0) ? '0 : regs[rt];
    assign imm_sext = {{(DATA_W-7){ir_reg[15]}}, ir_reg[15:9]};

    // One adder serves add/sub/addi and load/store address; sub is A + ~B + 1.
    logic              sub_op, alu_carry;
    logic [DATA_W-1:0] opb, alu_res;
    logic [DATA_W:0]   sum_ext;
    always_comb begin
        opb       = is_r ? b_reg : imm_reg;
        sub_op    = is_r && (funct == 4'd1);
        sum_ext   = {1'b0, a_reg} + {1'b0, (sub_op ? ~opb : opb)} + {{DATA_W{1'b0}}, sub_op};
        alu_res   = sum_ext[DATA_W-1:0];
        alu_carry = sum_ext[DATA_W];
        if (is_r) begin
            case (funct)
                4'd2: begin alu_res = a_reg & b_reg; alu_carry = 1'b0; end
                4'd3: begin alu_res = a_reg | b_reg; alu_carry = 1'b0; end
                4'd4: begin
                    alu_res   = {{(DATA_W-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
                    alu_carry = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            pc_reg    <= DATA_W'(RESET_PC);
            ir_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            imm_reg   <= '0;
            res_reg   <= '0;
            zero_reg  <= 1'b0;
            neg_reg   <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: if (bus.imem_ack) begin
                    ir_reg    <= bus.imem_rdata;
                    pc_reg    <= pc_reg + DATA_W'(PC_STEP);
                    state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    a_reg     <= rs_val;
                    b_reg     <= rt_val;
                    imm_reg   <= imm_sext;
                    state_reg <= is_halt ? S_HALTED : S_EXEC;
                end
                S_EXEC: begin
                    if (r_valid || is_addi || is_lw || is_sw)
                        res_reg <= alu_res;
                    if (r_valid || is_addi) begin
                        zero_reg  <= (alu_res == '0);
                        neg_reg   <= alu_res[DATA_W-1];
                        carry_reg <= alu_carry;
                    end
                    // pc_reg already points past the branch, so only the scaled offset is added.
                    if (is_beq && (a_reg == b_reg))
                        pc_reg <= pc_reg + imm_reg * DATA_W'(PC_STEP);
                    if (is_lw || is_sw)
                        state_reg <= S_MEM;
                    else if (r_valid || is_addi)
                        state_reg <= S_WB;
                    else
                        state_reg <= S_FETCH;
                end
                S_MEM: if (bus.dmem_ack) begin
                    if (is_lw) begin
                        res_reg   <= bus.dmem_rdata;
                        state_reg <= S_WB;
                    end else begin
                        state_reg <= S_FETCH;
                    end
                end
                S_WB:     state_reg <= S_FETCH;
                S_HALTED: state_reg <= S_HALTED;
                default:  state_reg <= S_FETCH;
            endcase
        end
    end

    logic [2:0] wb_idx;
    assign wb_idx = is_r ? rd : rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (state_reg == S_WB && wb_idx != 3'd0) begin
            regs[wb_idx] <= res_reg;
        end
    end

    // Requests are gated by rst so they drop immediately, even mid-handshake.
    assign bus.imem_req   = (state_reg == S_FETCH) && !rst;
    assign bus.imem_addr  = pc_reg;
    assign bus.dmem_req   = (state_reg == S_MEM) && !rst;
    assign bus.dmem_we    = (state_reg == S_MEM) && is_sw && !rst;
    assign bus.dmem_addr  = res_reg;
    assign bus.dmem_wdata = b_reg;

    assign halted     = (state_reg == S_HALTED);
    assign retire     = !rst && ((state_reg == S_WB)
                      || (state_reg == S_EXEC && (is_beq || is_nop))
                      || (state_reg == S_MEM && bus.dmem_ack && is_sw)
                      || (state_reg == S_DECODE && is_halt));
    assign flag_zero  = zero_reg;
    assign flag_neg   = neg_reg;
    assign flag_carry = carry_reg;
endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the 16-bit single-cycle processor.
- Each instruction is executed by an FSM over several cycles: FETCH, DECODE, EXEC, MEM, WB.
- Instruction and data memories sit outside the block and are reached through req/ack handshakes, so wait-state memories are supported.
- Adds a data-width parameter, an internal register file with r0 hardwired to zero, BEQ, HALT, registered ALU flags and a retire pulse.

Parameters:
DATA_W, 16, datapath/register/data-memory width (8..32); instructions are always 16 bits
NREGS, 8, register count; fixed by the 3-bit register fields
RESET_PC, 0, PC value after reset
PC_STEP, 2, PC increment per instruction; also the branch-offset scale

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req  out  1  instruction fetch request
imem_addr  out  DATA_W  fetch address (= PC)
imem_rdata  in  16  instruction; valid in the ack cycle
imem_ack  in  1  fetch complete
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  DATA_W  data address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data; valid in the ack cycle
dmem_ack  in  1  data access complete
halted  out  1  core stopped by HALT
retire  out  1  one-cycle pulse when an instruction completes
flag_zero, flag_neg, flag_carry  out  1 each  registered ALU flags

Behaviour:
- Clocking/reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Values on reset:
  - PC=RESET_PC, state=FETCH.
  - All registers 0.
  - Every output 0.
  - A reset during any state, including mid-handshake, drops imem_req/dmem_req on the next edge and discards the in-flight instruction.
- Instruction fields:
  - op=[2:0], rs=[5:3], rt=[8:6], rd=[11:9], funct=[15:12].
  - imm7=[15:9], sign-extended to DATA_W.
- Opcodes:
  - 000 R-type: rd = rs OP rt. funct: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed, result 1/0). Other funct values are a NOP.
  - 001 ADDI: rt = rs + imm.
  - 010 LW: rt = mem[rs+imm].
  - 011 SW: mem[rs+imm] = rt.
  - 100 BEQ: if rs==rt, PC = PC+PC_STEP+imm*PC_STEP; otherwise PC = PC+PC_STEP.
  - 111 HALT.
  - 101, 110: NOP.
- Register file: reads of r0 return 0; writes to r0 are ignored. Arithmetic wraps modulo 2^DATA_W.
- Handshake:
  - req rises on entry to FETCH or MEM.
  - req, addr, we and wdata are held stable until the cycle in which ack=1 is sampled. ack in that same first cycle is legal.
  - req deasserts on the following edge.
  - ack seen while req=0 is ignored.
- FSM transitions:
  - FETCH: on imem_ack, latch the instruction and PC+=PC_STEP, then go to DECODE.
  - DECODE: latch rs/rt values and imm. HALT goes to HALTED; everything else goes to EXEC.
  - EXEC:
    - ALU operation; flags are updated for R-type (valid funct) and ADDI only.
    - BEQ updates the PC, then FETCH.
    - LW/SW go to MEM.
    - R/ADDI go to WB.
    - NOP goes to FETCH.
  - MEM: on dmem_ack, LW captures rdata and goes to WB; SW goes to FETCH.
  - WB: register write, then FETCH.
  - HALTED: halted=1, no requests; leaves only by rst.
- retire:
  - Pulses high in the final cycle of each instruction: WB; EXEC for BEQ/NOP; MEM ack cycle for SW; DECODE for HALT.
- Latency with zero-wait memory:
  - R/ADDI 4 cycles, LW 5, SW 4, BEQ/NOP 3, HALT 2.
  - Each wait cycle adds 1.
- Flags:
  - zero = (result==0).
  - neg = result[DATA_W-1].
  - carry = carry-out of the DATA_W-bit adder; for sub this is the A+~B+1 carry, so 1 means no borrow. carry = 0 for and/or/slt.
- PC wrap-around: modulo 2^DATA_W, no trap.

Test Plan:
- Reset, zero-wait memories, program "ADDI r1,r0,5; ADDI r2,r0,-3; R add r3,r1,r2; HALT":
  - Response: r3=2, flag_carry=1, flag_zero=0, four retire pulses, halted=1 after 14 cycles.
  - Response: imem_addr sequence 0,2,4,6.
- SW r1→[r0+4] then LW r4←[r0+4] with dmem_ack delayed 3 cycles:
  - Response: dmem_req/addr=4/wdata=5 held 4 cycles with we=1, then we=0.
  - Response: r4=5; LW takes 8 cycles.
- BEQ r1,r1,imm=-2 at PC=8 → next imem_addr=6. BEQ r1,r2 (unequal) at PC=8 → next imem_addr=10.
- R sub r5,r1,r1 → r5=0, flag_zero=1, flag_carry=1. slt r6,r2,r1 (−3<5) → r6=1. ADDI r0,r0,7 → r0 still reads 0.
- DATA_W=8 build: ADDI r1,r0,-1 then add r2,r1,r1 → r2=0xFE, flag_carry=1, flag_neg=1.
- Assert rst while imem_req is waiting (ack held low) → imem_req=0 next cycle, PC=RESET_PC, registers 0; fetch restarts at RESET_PC after rst falls.
